a_ctrls_tx: RTL and testbench
=============================

# a_ctrls_tx

Control-panel-side serializer for the analog-controls link. It latches `N_CH` 8-bit control values and transmits them as one framed burst on a single wire. Each frame is a sync byte, the channel bytes and a checksum byte, and every byte is sent as UART 8N1. The block drives the `CTRL_RX_1` / `CTRL_RX_2` inputs of the theremin FPGA, so it is the transmit end of the link that `a_ctrls` receives.

## Interface
Parameters:
- `fCLK`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115_200, line bit rate.
  - Bit period `BIT_T = fCLK/BAUD`, integer division, truncated.
  - `BIT_T` ≥ 2 is required.
- `N_CH`, 7, number of channel bytes per frame.
- `SYNC`, 8'hA5, frame sync byte.

Ports:
- `clk` input 1: single clock; every flop is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in` input [7:0] x [0:N_CH-1]: channel values, unpacked array, element 0 transmitted first.
- `go` input 1: frame request, sampled at the rising edge.
- `busy` output 1: high while a frame is in flight.
- `done` output 1: one-cycle pulse at the end of a frame.
- `CTRL_TX` output 1: serial line, idles high, registered.

## Operation
- State machine: IDLE, START, DATA, STOP.
  - IDLE → START on `go`=1.
  - START → DATA after `BIT_T` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START when more bytes remain in the frame.
  - STOP → IDLE after the last byte.
- On an accepted `go` (state IDLE), all of `in[0..N_CH-1]` is copied into shadow registers. Changes on `in` mid-frame have no effect on the current frame.
- `go` while `busy`=1 is ignored: no queuing, no error flag.
- Byte sequence: `SYNC`, `in[0]` … `in[N_CH-1]`, then `CHK`.
  - `CHK` = sum of the `N_CH` latched channel bytes, modulo 256. `SYNC` is excluded from the sum.
  - The checksum accumulates in an 8-bit register with wrap-around.
- Byte format:
  - start bit 0;
  - data bits d0..d7, LSB first;
  - stop bit 1.
  - No idle gap is inserted between the bytes of a frame.
- Counters:
  - bit-time counter, 0..`BIT_T`-1;
  - bit index, 0..7;
  - byte index, 0..`N_CH`+1.
- Reset values: `CTRL_TX`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- Reset asserted mid-frame:
  - `CTRL_TX` returns to 1 asynchronously.
  - The frame is abandoned and no `done` pulse is issued.
  - After reset release the block waits in IDLE for a new `go`.

## Timing
- Let cycle G be the edge where `go`=1 is sampled in IDLE.
  - From the G+1 output, `CTRL_TX`=0 (start bit of `SYNC`) and `busy`=1.
- Every line bit is held for exactly `BIT_T` cycles.
- Frame length is `(N_CH+2)*10*BIT_T` cycles, counted from the first start-bit cycle through the final stop-bit cycle.
- In the cycle after the final stop bit completes:
  - `done`=1 for one cycle;
  - `busy`=0 in that same cycle;
  - state is IDLE and `CTRL_TX` stays 1.
- `go`=1 in the `done` cycle is accepted. The next start bit then appears on the following cycle (minimum back-to-back inter-frame gap: 1 cycle).
- `go` held high continuously gives back-to-back frames with a 1-cycle high gap between them.
- Fixed latency from `go` to the first line transition: 1 cycle.

## Test plan
- Basic frame:
  - Stimulus: `fCLK`=50M, `BAUD`=10M (`BIT_T`=5); after reset, `in`={01,02,03,04,05,06,07}; pulse `go`.
  - Required: decoded bytes A5 01 02 03 04 05 06 07 1C.
  - Required: `busy` high for exactly 450 cycles, `done` one cycle high, `CTRL_TX` high afterwards.
- Checksum wrap and data latching:
  - Stimulus: `in` all FF, pulse `go`, then change `in` to 00 two cycles after `go`.
  - Required: seven FF data bytes, then `CHK`=F9.
- Ignored request:
  - Stimulus: second `go` pulse at cycle 200 of a frame.
  - Required: single frame of 450 cycles; exactly one `done`; no second frame.
- Back-to-back:
  - Stimulus: `go` held high for 1000 cycles.
  - Required: two complete frames separated by one high cycle; a third frame starts at cycle 902.
- Reset mid-frame:
  - Stimulus: assert `reset_n`=0 at cycle 123 of a frame.
  - Required: `CTRL_TX`=1 and `busy`=0 immediately (asynchronous); no `done`.
  - Required: a fresh `go` after release gives a correct full frame.
- Bit timing:
  - Stimulus: `BAUD`=115_200.
  - Required: every bit lasts 434 cycles; the first start-bit edge occurs 1 cycle after `go`.

Source files
------------

// File: rtl/a_ctrls_tx.sv
// a_ctrls_tx : serial transmitter for the analog-controls link (control-panel side).
// On go, it latches N_CH channel bytes and sends one frame: SYNC, in[0..N_CH-1], CHK.
// Each byte goes out as UART 8N1 and there is no gap between the bytes of a frame.
// CHK is the 8-bit wrapping sum of the channel bytes. SYNC is not part of the sum.
//
// Ports:
//   clk      - clock (rising edge)
//   reset_n  - async active-low reset
//   in       - N_CH channel bytes, element 0 sent first
//   go       - frame request; accepted only in IDLE
//   busy     - high while a frame is in flight
//   done     - one-cycle pulse after the last stop bit
//   CTRL_TX  - registered serial line, idles high
module a_ctrls_tx #(
  parameter int         fCLK = 50_000_000,
  parameter int         BAUD = 115_200,
  parameter int         N_CH = 7,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in [0:N_CH-1],
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic       CTRL_TX
);

  localparam int BIT_T = fCLK / BAUD;
  localparam int CW    = $clog2(BIT_T);
  localparam int BW    = $clog2(N_CH + 2);
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_CH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [BW-1:0] byte_idx, byte_nxt;
  logic [7:0]    shadow [0:N_CH-1];
  logic [7:0]    chk;
  logic [7:0]    cur_ch, nxt_byte;
  logic          tick, last_stop, tx_nxt;

  assign tick = (cnt == CW'(BIT_T - 1));

  // Channel byte that is being sent now. It feeds the checksum. Zero outside the channel slots.
  always_comb begin
    cur_ch = 8'h00;
    for (int i = 0; i < N_CH; i++)
      if (byte_idx == BW'(i + 1)) cur_ch = shadow[i];
  end

  // Byte that will be on the line next cycle. CTRL_TX is registered, so the line
  // value is computed from the next-state values.
  always_comb begin
    nxt_byte = SYNC;
    if (byte_nxt == LAST_BYTE) nxt_byte = chk;
    for (int i = 0; i < N_CH; i++)
      if (byte_nxt == BW'(i + 1)) nxt_byte = shadow[i];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      CTRL_TX  <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      CTRL_TX  <= tx_nxt;
      done     <= last_stop;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    last_stop = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_nxt = START;
        cnt_nxt   = '0;
        bit_nxt   = '0;
        byte_nxt  = '0;
      end
      START: if (tick) begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        bit_nxt   = '0;
      end else cnt_nxt = cnt + CW'(1);
      DATA: if (tick) begin
        cnt_nxt = '0;
        if (bit_idx == 3'd7) state_nxt = STOP;
        else                 bit_nxt   = bit_idx + 3'd1;
      end else cnt_nxt = cnt + CW'(1);
      STOP: if (tick) begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (byte_idx == LAST_BYTE) begin
          state_nxt = IDLE;
          byte_nxt  = '0;
          last_stop = 1'b1;
        end else begin
          state_nxt = START;
          byte_nxt  = byte_idx + BW'(1);
        end
      end else cnt_nxt = cnt + CW'(1);
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = nxt_byte[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  // The frame data is captured when go is accepted. The checksum is updated when
  // the last data bit of each channel byte ends. This is before the checksum byte
  // is sent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk <= 8'h00;
      for (int i = 0; i < N_CH; i++) shadow[i] <= 8'h00;
    end else if (state == IDLE && go) begin
      chk <= 8'h00;
      for (int i = 0; i < N_CH; i++) shadow[i] <= in[i];
    end else if (state == DATA && tick && bit_idx == 3'd7 &&
                 byte_idx != '0 && byte_idx != LAST_BYTE) begin
      chk <= chk + cur_ch;
    end
  end

endmodule

// File: tb/tb_a_ctrls_tx.sv
module tb_a_ctrls_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [7:0] in_f [0:6];
  logic [7:0] in_s [0:6];
  logic       go_f, go_s;
  logic       busy_f, done_f, tx_f;
  logic       busy_s, done_s, tx_s;

  a_ctrls_tx #(.fCLK(50_000_000), .BAUD(10_000_000), .N_CH(7), .SYNC(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .in(in_f), .go(go_f),
    .busy(busy_f), .done(done_f), .CTRL_TX(tx_f));

  a_ctrls_tx #(.fCLK(50_000_000), .BAUD(115_200), .N_CH(7), .SYNC(8'hA5)) dut_slow (
    .clk(clk), .reset_n(reset_n), .in(in_s), .go(go_s),
    .busy(busy_s), .done(done_s), .CTRL_TX(tx_s));

  // Selects which DUT the frame-capture task observes
  logic sel;
  logic tx_m, busy_m, done_m;
  assign tx_m   = sel ? tx_s   : tx_f;
  assign busy_m = sel ? busy_s : busy_f;
  assign done_m = sel ? done_s : done_f;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] got   [0:8];
  logic [7:0] exp_b [0:8];
  bit         fr_ok;
  int         fr_busy;

  // Called at the negedge of the first start-bit cycle. Each of the 90 bit windows
  // must be constant for bt samples. Returns at the negedge of the cycle after the frame.
  task automatic cap_frame(input int bt);
    logic [7:0] b;
    logic v0;
    fr_ok = 1'b1;
    fr_busy = 0;
    for (int k = 0; k < 9; k++) begin
      b = 8'h00;
      for (int j = 0; j < 10; j++) begin
        v0 = tx_m;
        for (int c = 0; c < bt; c++) begin
          if (tx_m !== v0) fr_ok = 1'b0;
          if (busy_m === 1'b1) fr_busy++;
          if (done_m !== 1'b0) fr_ok = 1'b0;
          @(negedge clk);
        end
        if (j == 0 && v0 !== 1'b0) fr_ok = 1'b0;
        if (j == 9 && v0 !== 1'b1) fr_ok = 1'b0;
        if (j >= 1 && j <= 8) b[j-1] = v0;
      end
      got[k] = b;
    end
  endtask

  task automatic frame_end(input string nm, input int bt);
    check({nm, "_timing"}, 32'(fr_ok), 1);
    check({nm, "_busy_cycles"}, fr_busy, bt * 90);
    check({nm, "_done"}, 32'(done_m), 1);
    check({nm, "_busy_low_at_done"}, 32'(busy_m), 0);
    check({nm, "_tx_high_at_done"}, 32'(tx_m), 1);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_byte%0d", nm, k), 32'(got[k]), 32'(exp_b[k]));
  endtask

  task automatic set_exp(input logic [55:0] ch, input logic [7:0] c);
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 7; i++) exp_b[i+1] = ch[8*(6-i) +: 8];
    exp_b[8] = c;
  endtask

  typedef struct {
    logic [55:0] ch;   // in[0] in the top byte
    logic [7:0]  chk;
    bit          chg;  // set in to 00 two cycles after go
  } vec_t;

  vec_t tv [5];
  int   dcnt;
  bit   lowseen;

  initial begin
    tv[0] = '{ch: 56'h01020304050607, chk: 8'h1C, chg: 1'b0};
    tv[1] = '{ch: 56'hFFFFFFFFFFFFFF, chk: 8'hF9, chg: 1'b1};
    tv[2] = '{ch: 56'h00000000000000, chk: 8'h00, chg: 1'b0};
    tv[3] = '{ch: 56'h80808080000001, chk: 8'h01, chg: 1'b0};
    tv[4] = '{ch: 56'h123456789ABCDE, chk: 8'h48, chg: 1'b0};

    sel = 1'b0;
    go_f = 1'b0;
    go_s = 1'b0;
    for (int i = 0; i < 7; i++) begin in_f[i] = 8'h00; in_s[i] = 8'h00; end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_f), 1);
    check("rst_busy", 32'(busy_f), 0);
    check("rst_done", 32'(done_f), 0);
    check("rst_slow_tx", 32'(tx_s), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 7; i++) in_f[i] = tv[t].ch[8*(6-i) +: 8];
      set_exp(tv[t].ch, tv[t].chk);
      go_f = 1'b1;
      @(negedge clk);
      go_f = 1'b0;
      fork
        cap_frame(5);
        begin
          if (tv[t].chg) begin
            @(negedge clk);
            for (int i = 0; i < 7; i++) in_f[i] = 8'h00;
          end
        end
      join
      frame_end($sformatf("vec%0d", t), 5);
      repeat (3) @(negedge clk);
    end

    // A second go at cycle 200 of a frame is ignored
    for (int i = 0; i < 7; i++) in_f[i] = 8'(i + 1);
    set_exp(56'h01020304050607, 8'h1C);
    go_f = 1'b1;
    @(negedge clk);
    go_f = 1'b0;
    fork
      cap_frame(5);
      begin
        repeat (199) @(negedge clk);
        go_f = 1'b1;
        @(negedge clk);
        go_f = 1'b0;
      end
    join
    frame_end("ignore", 5);
    dcnt = 0;
    lowseen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done_f) dcnt++;
      if (tx_f !== 1'b1 || busy_f !== 1'b0) lowseen = 1'b1;
    end
    check("ignore_no_extra_done", dcnt, 0);
    check("ignore_no_second_frame", 32'(lowseen), 0);

    // Back-to-back frames with go held high
    go_f = 1'b1;
    @(negedge clk);
    cap_frame(5);
    frame_end("b2b_f1", 5);
    @(negedge clk);
    cap_frame(5);
    frame_end("b2b_f2", 5);
    @(negedge clk);
    check("b2b_third_start_tx", 32'(tx_f), 0);
    check("b2b_third_start_busy", 32'(busy_f), 1);
    repeat (98) @(negedge clk);
    go_f = 1'b0;
    for (int c = 0; c < 600 && !done_f; c++) @(negedge clk);
    check("b2b_third_done", 32'(done_f), 1);
    repeat (3) @(negedge clk);

    // Reset asserted at cycle 123 of a frame
    go_f = 1'b1;
    @(negedge clk);
    go_f = 1'b0;
    repeat (122) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_tx_async", 32'(tx_f), 1);
    check("rstmid_busy_async", 32'(busy_f), 0);
    @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    lowseen = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done_f) dcnt++;
      if (tx_f !== 1'b1 || busy_f !== 1'b0) lowseen = 1'b1;
    end
    check("rstmid_no_done", dcnt, 0);
    check("rstmid_stays_idle", 32'(lowseen), 0);
    go_f = 1'b1;
    @(negedge clk);
    go_f = 1'b0;
    cap_frame(5);
    frame_end("rstmid_fresh", 5);

    // Full-rate bit timing: BIT_T = 434
    sel = 1'b1;
    for (int i = 0; i < 7; i++) in_s[i] = 8'(8'h11 * (i + 1));
    set_exp(56'h11223344556677, 8'hDC);
    @(negedge clk);
    check("slow_idle_before_go", 32'(tx_s), 1);
    go_s = 1'b1;
    @(negedge clk);
    go_s = 1'b0;
    check("slow_first_edge", 32'(tx_s), 0);
    cap_frame(434);
    frame_end("slow", 434);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
